// File: rtl/hog_svm_pkg.sv
// Shared definitions for the HOG feature feeder: default feature-word and
// beat geometry, derived widths, the server FSM state type and a small
// width helper.
package hog_svm_pkg;

  // Default feature word format (Q4.28) and SVM beat width
  localparam int unsigned FEA_I_DEF  = 4;
  localparam int unsigned FEA_F_DEF  = 28;
  localparam int unsigned DATA_W_DEF = 768;
  localparam int unsigned DEPTH_DEF  = 4;

  // Derived geometry: word width and words per beat
  localparam int unsigned FEA_W_DEF = FEA_I_DEF + FEA_F_DEF;
  localparam int unsigned WPB_DEF   = DATA_W_DEF / FEA_W_DEF;

  // Beat server states
  typedef enum logic {
    SRV_IDLE = 1'b0,
    SRV_SEND = 1'b1
  } srv_state_t;

  // Bits needed to index n items (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hog_beat_fifo.sv
// DEPTH x DATA_W beat buffer for the HOG feature feeder.
// Pointers wrap modulo DEPTH (power of two); occupancy is a separate counter
// one bit wider than the pointers, so full and empty are unambiguous.
// A push and a pop in the same cycle both succeed even when full.
// flush has priority over push/pop and clears pointers and occupancy.
// The storage array itself is not reset.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   flush          synchronous clear
//   push/push_data write one beat
//   pop            drop the head beat
//   head_c         current head beat (combinational read)
//   full, empty    registered occupancy flags
module hog_beat_fifo
  import hog_svm_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_c,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = cnt_width(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_nxt;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is only legal when the head leaves this cycle
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  // Next occupancy
  always_comb begin
    occ_nxt = occ;
    if (flush) begin
      occ_nxt = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   occ_nxt = occ + OCC_W'(1);
        2'b01:   occ_nxt = occ - OCC_W'(1);
        default: occ_nxt = occ;
      endcase
    end
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ   <= occ_nxt;
      full  <= (occ_nxt == OCC_W'(DEPTH));
      empty <= (occ_nxt == '0);
    end
  end

  // Beat storage, intentionally without reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hog_feature_feeder.sv
// HOG feature feeder: packs FEA_W-bit feature words into DATA_W-bit beats
// (first word in the LSBs), buffers up to DEPTH beats and serves them to the
// SVM one at a time on request with a one-cycle ready strobe.
//
// Optional feature: define HOG_FEEDER_UNDERFLOW_CNT_EN to add underflow_cnt,
// a saturating count of cycles where the SVM requests while the buffer is
// empty and the server is idle.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   fea_valid, fea_data    feature word input
//   fea_ready              word accepted this cycle when fea_valid
//   flush                  synchronous clear of partial beat and buffer
//   request                SVM level request for the next beat
//   ready, i_data          beat strobe and beat data (held between strobes)
//   empty                  no complete beat buffered
//   underflow_cnt          (optional) request-while-empty cycle count
module hog_feature_feeder
  import hog_svm_pkg::*;
#(
  parameter int unsigned FEA_I  = FEA_I_DEF,
  parameter int unsigned FEA_F  = FEA_F_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fea_valid,
  input  logic [FEA_I+FEA_F-1:0] fea_data,
  output logic                   fea_ready,
  input  logic                   flush,
  input  logic                   request,
  output logic                   ready,
  output logic [DATA_W-1:0]      i_data,
  output logic                   empty
`ifdef HOG_FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]            underflow_cnt
`endif
);

  localparam int unsigned FEA_W = FEA_I + FEA_F;
  localparam int unsigned WPB   = DATA_W / FEA_W;
  localparam int unsigned CNT_W = cnt_width(WPB);

  logic [CNT_W-1:0]           word_cnt;
  logic [(WPB-1)*FEA_W-1:0]   beat_q;
  logic [DATA_W-1:0]          push_beat;
  logic [DATA_W-1:0]          head_c;
  logic                       last_word;
  logic                       xfer;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  srv_state_t                 state;

  // The server pops on the single SEND cycle unless flush overrides it
  assign pop       = (state == SRV_SEND) && !flush;
  assign last_word = (word_cnt == CNT_W'(WPB - 1));
  // Only the beat-completing word can stall, and only if nothing leaves
  assign fea_ready = !(last_word && fifo_full && !pop);
  assign xfer      = fea_valid && fea_ready;
  assign push      = xfer && last_word && !flush;
  // Final word bypasses the assembly register straight into the buffer
  assign push_beat = {fea_data, beat_q};
  assign empty     = fifo_empty;

  // Word position within the beat being assembled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (flush) begin
      word_cnt <= '0;
    end else if (xfer) begin
      word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
    end
  end

  // Partial beat assembly; stale words are always overwritten before reuse
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < WPB - 1; k++) begin
      if (xfer && !flush && (word_cnt == CNT_W'(k))) begin
        beat_q[k*FEA_W +: FEA_W] <= fea_data;
      end
    end
  end

  hog_beat_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .head_c    (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Beat server: IDLE waits for request with data, SEND strobes one beat.
  // Returning to IDLE after every strobe guarantees a gap between beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= SRV_IDLE;
      ready  <= 1'b0;
      i_data <= '0;
    end else if (flush) begin
      state <= SRV_IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        SRV_IDLE: begin
          ready <= 1'b0;
          if (request && !fifo_empty) state <= SRV_SEND;
        end
        SRV_SEND: begin
          ready  <= 1'b1;
          i_data <= head_c;
          state  <= SRV_IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= SRV_IDLE;
        end
      endcase
    end
  end

`ifdef HOG_FEEDER_UNDERFLOW_CNT_EN
  // Saturating count of starved request cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow_cnt <= '0;
    end else if (flush) begin
      underflow_cnt <= '0;
    end else if (request && fifo_empty && (state == SRV_IDLE)
                 && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule
